vote_tally: RTL and testbench

//   Downstream consumer of the per-candidate button debouncers. Accepts their
//   one-cycle valid_vote pulses and enforces one vote per officer arming.

---
 rtl/vote_tally.sv | 64 ++++++
 tb/tb_vote_tally.sv | 108 ++++++++++
 2 files changed

// File: rtl/vote_tally.sv
// vote_tally: one-vote-per-arming ballot core with saturating per-candidate counters; VOTE_TALLY_TOTAL_EN adds a running total_votes output
module vote_tally #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 mode,
  input  logic                                 booth_arm,
  input  logic [NUM_CAND-1:0]                  valid_vote,
  input  logic [$clog2(NUM_CAND)-1:0]          disp_sel,
  output logic                                 booth_ready,
  output logic                                 vote_ack,
  output logic                                 vote_err,
`ifdef VOTE_TALLY_TOTAL_EN
  output logic [CNT_W+$clog2(NUM_CAND)-1:0]    total_votes,
`endif
  output logic [CNT_W-1:0]                     disp_count
);
  localparam int SW = $clog2(NUM_CAND);
  localparam logic [SW:0] NC = (SW+1)'(NUM_CAND);
  typedef enum logic {IDLE, ARMED} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] count [NUM_CAND];
  logic [NUM_CAND-1:0] sat;
  logic live, one_hot, accept, reject;
  for (genvar i = 0; i < NUM_CAND; i++) begin : g_sat
    assign sat[i] = &count[i];
  end
  assign booth_ready = state == ARMED;
  // vote classification and next state; saturated or multi-press votes keep the booth armed
  always_comb begin
    live     = state == ARMED && !mode;
    one_hot  = valid_vote != '0 && (valid_vote & (valid_vote - NUM_CAND'(1))) == '0;
    accept   = live && one_hot && !(|(valid_vote & sat));
    reject   = live && |valid_vote && !accept;
    state_nx = state == IDLE ? (booth_arm && !mode ? ARMED : IDLE) : (mode || accept ? IDLE : ARMED);
  end
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // per-candidate counters, bumped only on an accepted vote
  always_ff @(posedge clock or posedge reset)
    if (reset) for (int i = 0; i < NUM_CAND; i++) count[i] <= '0;
    else for (int i = 0; i < NUM_CAND; i++) if (accept && valid_vote[i]) count[i] <= count[i] + CNT_W'(1);
  // registered status pulses and result-mode readout
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      vote_ack   <= 1'b0;
      vote_err   <= 1'b0;
      disp_count <= '0;
    end else begin
      vote_ack   <= accept;
      vote_err   <= reject;
      disp_count <= mode && {1'b0, disp_sel} < NC ? count[disp_sel] : '0;
    end
`ifdef VOTE_TALLY_TOTAL_EN
  // running total of accepted votes, wide enough to never wrap
  always_ff @(posedge clock or posedge reset)
    if (reset) total_votes <= '0;
    else if (accept) total_votes <= total_votes + (CNT_W+SW)'(1);
`endif
endmodule

// File: tb/tb_vote_tally.sv
// tb_vote_tally: randomized and directed checks of vote_tally against a behavioural ballot model
module tb_vote_tally;
  localparam int NC = 4;
  localparam int CW = 2;
  localparam int MAXC = (1 << CW) - 1;
  logic clock = 0, reset = 1, mode = 0, booth_arm = 0;
  logic [NC-1:0] valid_vote = '0;
  logic [1:0] disp_sel = '0;
  logic booth_ready, vote_ack, vote_err;
  logic [CW-1:0] disp_count;
`ifdef VOTE_TALLY_TOTAL_EN
  logic [CW+1:0] total_votes;
`endif
  int n_vec = 0, n_err = 0;
  int m_cnt [NC];
  int m_total;
  bit m_armed, e_ack, e_err;
  int e_disp;
  vote_tally #(.NUM_CAND(NC), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .mode(mode), .booth_arm(booth_arm),
    .valid_vote(valid_vote), .disp_sel(disp_sel),
    .booth_ready(booth_ready), .vote_ack(vote_ack), .vote_err(vote_err),
`ifdef VOTE_TALLY_TOTAL_EN
    .total_votes(total_votes),
`endif
    .disp_count(disp_count));
  always #5 clock = ~clock;
  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    m_total = 0; m_armed = 0; e_ack = 0; e_err = 0; e_disp = 0;
  endtask
  task automatic check_all(input string tag);
    check({tag, ".ready"}, int'(booth_ready), int'(m_armed));
    check({tag, ".ack"}, int'(vote_ack), int'(e_ack));
    check({tag, ".err"}, int'(vote_err), int'(e_err));
    check({tag, ".disp"}, int'(disp_count), e_disp);
`ifdef VOTE_TALLY_TOTAL_EN
    check({tag, ".total"}, int'(total_votes), m_total);
`endif
  endtask
  // apply one cycle of inputs, advance the model, check outputs at the following negedge
  task automatic step(input string tag, input bit md, input bit ar, input logic [NC-1:0] vv, input int sl);
    int n, idx;
    mode = md; booth_arm = ar; valid_vote = vv; disp_sel = 2'(sl);
    e_disp = md && sl < NC ? m_cnt[sl] : 0;
    e_ack = 0; e_err = 0;
    n = $countones(vv);
    idx = 0;
    for (int i = 0; i < NC; i++) if (vv[i]) idx = i;
    if (m_armed && !md && n == 1) begin
      if (m_cnt[idx] == MAXC) e_err = 1;
      else begin m_cnt[idx]++; m_total++; e_ack = 1; end
    end else if (m_armed && !md && n > 1) e_err = 1;
    m_armed = m_armed ? !(md || e_ack) : (ar && !md);
    @(posedge clock);
    @(negedge clock);
    check_all(tag);
  endtask
  initial begin
    logic [NC-1:0] vv;
    int r;
    model_reset();
    #12 @(negedge clock) reset = 0;
    check_all("reset");
    step("arm", 0, 1, 4'b0000, 0);
    #2 reset = 1;
    #1 check("async_rst.ready", int'(booth_ready), 0);
    check("async_rst.disp", int'(disp_count), 0);
    model_reset();
    @(negedge clock) reset = 0;
    step("post_rst", 1, 0, 4'b0000, 0);
    step("t2.arm", 0, 1, 4'b0000, 0);
    step("t2.vote", 0, 0, 4'b0010, 0);
    step("t2.show", 1, 0, 4'b0000, 1);
    step("t3.idle", 0, 0, 4'b0100, 0);
    step("t3.again", 0, 0, 4'b0010, 0);
    step("t3.show", 1, 0, 4'b0000, 2);
    step("t4.arm", 0, 1, 4'b0000, 0);
    step("t4.multi", 0, 0, 4'b0011, 0);
    step("t4.one", 0, 0, 4'b0001, 0);
    step("t4.show", 1, 0, 4'b0000, 0);
    for (int k = 0; k < 3; k++) begin
      step("t5.arm", 0, 1, 4'b0000, 0);
      step("t5.vote", 0, 0, 4'b1000, 0);
    end
    step("t5.arm2", 0, 1, 4'b0000, 0);
    step("t5.sat", 0, 0, 4'b1000, 0);
    step("t5.hold", 0, 1, 4'b0000, 0);
    step("t5.show", 1, 0, 4'b0000, 3);
    step("t6.arm", 0, 1, 4'b0000, 0);
    step("t6.abort", 1, 0, 4'b0100, 2);
    step("t6.idle", 0, 0, 4'b0100, 2);
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 9);
      vv = r < 4 ? 4'b0000 : r < 8 ? NC'(1 << $urandom_range(0, NC-1)) : NC'($urandom);
      step("rand", $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, vv, $urandom_range(0, NC-1));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
